// File: rtl/axis_pkg.sv
// axis_pkg: receive-FSM states and width helpers shared by the AXIS buffer blocks
package axis_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, IN_PKT = 2'b01, OVERSIZE = 2'b10} axis_rx_state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through synchronous FIFO, DEPTH a power of two
module axis_sync_fifo import axis_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [cnt_w(DEPTH)-1:0] level,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = ptr_w(DEPTH);
  localparam int LW = cnt_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  assign full = r_level == LW'(DEPTH);
  assign empty = r_level == '0;
  assign w_push = push & ~full;
  assign w_pop = pop & ~empty;
  assign rdata = r_mem[r_rptr];
  assign level = r_level;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_push);
      r_rptr <= r_rptr + AW'(w_pop);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wptr] <= wdata;
endmodule

// File: rtl/axis_slave_pbuf.sv
// axis_slave_pbuf: AXIS slave with packet FIFO, cut-through or store-and-forward release.
// Define AXIS_SLAVE_PBUF_STATS_EN to add the rx_pkt_count/rx_beat_count counters.
module axis_slave_pbuf import axis_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int STORE_FWD = 0,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_arst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  input  logic              data_ready,
  output logic [CNT_W-1:0]  fill_level,
  output logic [CNT_W-1:0]  pkt_stored,
  output logic              err_oversize
`ifdef AXIS_SLAVE_PBUF_STATS_EN
  ,
  output logic [31:0]       rx_pkt_count,
  output logic [31:0]       rx_beat_count
`endif
);
  axis_rx_state_t r_state, w_state_nx;
  logic r_run;
  logic [CNT_W-1:0] r_pkt;
  logic [DATA_W:0] w_rdata;
  logic w_full, w_empty, w_push, w_pop, w_release;
  axis_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(s_axis_aclk), .rst(s_axis_arst), .push(w_push), .pop(w_pop),
    .wdata({s_axis_tlast, s_axis_tdata}), .rdata(w_rdata), .level(fill_level),
    .full(w_full), .empty(w_empty)
  );
  // r_run holds tready low through the reset cycle and the one after it
  assign s_axis_tready = r_run & ~w_full;
  assign w_push = s_axis_tvalid & s_axis_tready;
  assign w_release = (STORE_FWD == 0) || (r_pkt != '0) || (r_state == OVERSIZE);
  assign data_valid = ~w_empty & w_release;
  assign w_pop = data_valid & data_ready;
  assign data_out = data_valid ? w_rdata[DATA_W-1:0] : '0;
  assign data_last = data_valid & w_rdata[DATA_W];
  assign pkt_stored = r_pkt;
  // full buffer with no complete packet can never drain: fall back to cut-through
  assign err_oversize = (STORE_FWD != 0) && (r_state == IN_PKT) && w_full && (r_pkt == '0);
  always_comb begin
    w_state_nx = err_oversize ? OVERSIZE :
                 !w_push ? r_state :
                 s_axis_tlast ? IDLE :
                 (r_state == IDLE) ? IN_PKT : r_state;
  end
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      r_state <= IDLE;
      r_run <= 1'b0;
      r_pkt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run <= 1'b1;
      r_pkt <= r_pkt + CNT_W'(w_push & s_axis_tlast) - CNT_W'(w_pop & data_last);
    end
  end
`ifdef AXIS_SLAVE_PBUF_STATS_EN
  logic [31:0] r_rx_pkt, r_rx_beat;
  assign rx_pkt_count = r_rx_pkt;
  assign rx_beat_count = r_rx_beat;
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      r_rx_pkt <= '0;
      r_rx_beat <= '0;
    end else begin
      r_rx_pkt <= r_rx_pkt + 32'(w_push & s_axis_tlast);
      r_rx_beat <= r_rx_beat + 32'(w_push);
    end
  end
`endif
endmodule

// File: tb/tb_axis_slave_pbuf.sv
// tb_axis_slave_pbuf: one stimulus drives cut-through/16, store-and-forward/16 and
// store-and-forward/8 instances, each checked every cycle against a queue model.
`timescale 1ns/1ps
module tb_axis_slave_pbuf;
  localparam int N = 3;
  function automatic int dep(input int i);
    return i == 2 ? 8 : 16;
  endfunction
  function automatic bit sfm(input int i);
    return i != 0;
  endfunction
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tdata;
  logic tvalid, tlast, ready;
  logic tready [N];
  logic [7:0] dout [N];
  logic dval [N], dlast [N], err [N];
  logic [4:0] fill [N], pkt [N];
  logic [31:0] rxp [N], rxb [N];
  int checks = 0, failures = 0, n_err_ov = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = $clog2(dep(g)) + 1;
    logic [CW-1:0] f, p;
    axis_slave_pbuf #(.DATA_W(8), .DEPTH(dep(g)), .STORE_FWD(g == 0 ? 0 : 1)) u_dut (
      .s_axis_aclk(clk), .s_axis_arst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast), .s_axis_tready(tready[g]), .data_out(dout[g]), .data_valid(dval[g]),
      .data_last(dlast[g]), .data_ready(ready), .fill_level(f), .pkt_stored(p), .err_oversize(err[g])
`ifdef AXIS_SLAVE_PBUF_STATS_EN
      , .rx_pkt_count(rxp[g]), .rx_beat_count(rxb[g])
`endif
    );
    assign fill[g] = 5'(f);
    assign pkt[g] = 5'(p);
  end
`ifndef AXIS_SLAVE_PBUF_STATS_EN
  initial for (int i = 0; i < N; i++) begin
    rxp[i] = '0;
    rxb[i] = '0;
  end
`endif
  // model: each buffer is a queue of {last, data}; packets stored = lasts in the queue
  logic [8:0] q [N][$];
  bit inpkt [N], ov [N], run [N];
  logic [31:0] m_rxp [N], m_rxb [N];
  function automatic int m_pkt(input int i);
    int n = 0;
    for (int k = 0; k < q[i].size(); k++) if (q[i][k][8]) n++;
    return n;
  endfunction
  function automatic bit m_tready(input int i);
    return run[i] && q[i].size() != dep(i);
  endfunction
  function automatic bit m_valid(input int i);
    return q[i].size() != 0 && (!sfm(i) || m_pkt(i) != 0 || ov[i]);
  endfunction
  function automatic bit m_err(input int i);
    return sfm(i) && inpkt[i] && !ov[i] && q[i].size() == dep(i) && m_pkt(i) == 0;
  endfunction
  task automatic step();
    for (int i = 0; i < N; i++) begin
      bit pu, po, e;
      if (rst) begin
        q[i].delete();
        inpkt[i] = 0;
        ov[i] = 0;
        run[i] = 0;
        m_rxp[i] = 0;
        m_rxb[i] = 0;
      end else begin
        pu = tvalid && m_tready(i);
        po = m_valid(i) && ready;
        e = m_err(i);
        if (po) void'(q[i].pop_front());
        if (pu) begin
          q[i].push_back({tlast, tdata});
          m_rxb[i] += 1;
          if (tlast) m_rxp[i] += 1;
        end
        if (e) ov[i] = 1;
        if (pu && tlast) begin
          inpkt[i] = 0;
          ov[i] = 0;
        end else if (pu) inpkt[i] = 1;
        run[i] = 1;
      end
    end
  endtask
  initial forever begin
    @(posedge clk);
    step();
  end
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask
  initial begin
    bit v;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        v = m_valid(i);
        chk("tready", i, 32'(tready[i]), 32'(m_tready(i)));
        chk("data_valid", i, 32'(dval[i]), 32'(v));
        chk("data_out", i, 32'(dout[i]), v ? 32'(q[i][0][7:0]) : 32'd0);
        chk("data_last", i, 32'(dlast[i]), v ? 32'(q[i][0][8]) : 32'd0);
        chk("fill_level", i, 32'(fill[i]), 32'(q[i].size()));
        chk("pkt_stored", i, 32'(pkt[i]), 32'(m_pkt(i)));
        chk("err_oversize", i, 32'(err[i]), 32'(m_err(i)));
`ifdef AXIS_SLAVE_PBUF_STATS_EN
        chk("rx_pkt_count", i, rxp[i], m_rxp[i]);
        chk("rx_beat_count", i, rxb[i], m_rxb[i]);
`endif
        if (i == 2 && err[i] === 1'b1) n_err_ov++;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // hold a beat until the depth-8 instance can take it
  task automatic send(input logic [7:0] d, input logic l);
    int w = 0;
    tvalid = 1'b1;
    tdata = d;
    tlast = l;
    while (tready[2] !== 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) chk("send_timeout", 2, 32'(w), 32'd0);
    @(negedge clk);
    tvalid = 1'b0;
  endtask
  initial begin
    tvalid = 0;
    tlast = 0;
    tdata = 0;
    ready = 0;
    cyc(2);
    rst = 0;
    chk("lit_tready_after_rst", 0, 32'(tready[0]), 32'd0);
    chk("lit_fill_after_rst", 0, 32'(fill[0]), 32'd0);
    cyc(1);
    // cut-through 4-beat packet
    ready = 1;
    send(8'hA0, 0);
    chk("lit_ct_valid_a0", 0, 32'(dval[0]), 32'd1);
    chk("lit_ct_data_a0", 0, 32'(dout[0]), 32'hA0);
    chk("lit_sf_hidden_a0", 1, 32'(dval[1]), 32'd0);
    send(8'hA1, 0);
    send(8'hA2, 0);
    send(8'hA3, 1);
    chk("lit_sf_valid_a3", 1, 32'(dval[1]), 32'd1);
    chk("lit_sf_data_a0", 1, 32'(dout[1]), 32'hA0);
    chk("lit_sf_pkt", 1, 32'(pkt[1]), 32'd1);
    cyc(20);
    chk("lit_ct_drained", 0, 32'(fill[0]), 32'd0);
    // backpressure: 20 single-beat packets with no pops
    ready = 0;
    tvalid = 1;
    tlast = 1;
    for (int i = 0; i < 20; i++) begin
      tdata = 8'(i);
      @(negedge clk);
    end
    chk("lit_bp_fill16", 0, 32'(fill[0]), 32'd16);
    chk("lit_bp_tready0", 0, 32'(tready[0]), 32'd0);
    chk("lit_bp_fill8", 2, 32'(fill[2]), 32'd8);
    tvalid = 0;
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("lit_bp_fill15", 0, 32'(fill[0]), 32'd15);
    chk("lit_bp_tready1", 0, 32'(tready[0]), 32'd1);
    tvalid = 1;
    tdata = 8'h55;
    @(negedge clk);
    chk("lit_bp_refill", 0, 32'(fill[0]), 32'd16);
    cyc(2);
    chk("lit_bp_one_more", 0, 32'(fill[0]), 32'd16);
    tvalid = 0;
    ready = 1;
    cyc(30);
    chk("lit_bp_drained", 0, 32'(fill[0]), 32'd0);
    // store-and-forward with gaps inside the packet
    send(8'h31, 0);
    cyc(2);
    send(8'h32, 0);
    cyc(2);
    chk("lit_sf_gap_hidden", 1, 32'(dval[1]), 32'd0);
    chk("lit_sf_gap_fill", 1, 32'(fill[1]), 32'd2);
    send(8'h33, 1);
    chk("lit_sf_gap_valid", 1, 32'(dval[1]), 32'd1);
    chk("lit_sf_gap_pkt1", 1, 32'(pkt[1]), 32'd1);
    cyc(10);
    chk("lit_sf_gap_pkt0", 1, 32'(pkt[1]), 32'd0);
    // 12-beat packet overflows the depth-8 store-and-forward buffer
    n_err_ov = 0;
    for (int i = 0; i < 12; i++) send(8'hC0 + 8'(i), i == 11);
    cyc(30);
    chk("lit_ov_err_once", 2, 32'(n_err_ov), 32'd1);
    chk("lit_ov_drained", 2, 32'(fill[2]), 32'd0);
    chk("lit_ov_sf16_clean", 1, 32'(pkt[1]), 32'd0);
    // reset in the middle of a packet
    ready = 0;
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 0);
    chk("lit_mid_fill5", 0, 32'(fill[0]), 32'd5);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("lit_rst_valid", i, 32'(dval[i]), 32'd0);
      chk("lit_rst_fill", i, 32'(fill[i]), 32'd0);
      chk("lit_rst_pkt", i, 32'(pkt[i]), 32'd0);
      chk("lit_rst_tready", i, 32'(tready[i]), 32'd0);
    end
    rst = 0;
    cyc(1);
    ready = 1;
    send(8'h61, 0);
    send(8'h62, 1);
    cyc(10);
    chk("lit_post_rst_drained", 1, 32'(fill[1]), 32'd0);
`ifdef AXIS_SLAVE_PBUF_STATS_EN
    rst = 1;
    cyc(1);
    chk("lit_stats_pkt_rst", 0, rxp[0], 32'd0);
    chk("lit_stats_beat_rst", 0, rxb[0], 32'd0);
    rst = 0;
    cyc(1);
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < (p == 2 ? 4 : 3); b++) send(8'(16 * p + b), b == (p == 2 ? 3 : 2));
    cyc(10);
    chk("lit_stats_pkt", 0, rxp[0], 32'd3);
    chk("lit_stats_beat", 0, rxb[0], 32'd10);
`endif
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_slave_pbuf.md
Name: axis_slave_pbuf

Overview:
- Parametrised AXI4-Stream slave with internal packet buffer; next generation of the team's single-beat AXIS slave.
- Accepts a DATA_W-wide stream into a DEPTH-entry FIFO and presents it to user logic through a valid/ready pop interface with a last flag.
- Two modes: cut-through (words visible as soon as stored) and store-and-forward (words visible only once a complete packet is buffered).
- Sits between an AXIS master and user datapath logic that needs backpressure-tolerant, packet-aware buffering.

Parameters:
- DATA_W, 8, tdata and data_out width in bits (>=1).
- DEPTH, 16, FIFO entries; power of two, >=2.
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward.
- CNT_W, $clog2(DEPTH)+1, width of the level and packet-count fields (derived; do not override).

Ports:
- s_axis_aclk  in  1  sole clock; all logic is on the rising edge.
- s_axis_arst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  DATA_W  stream data.
- s_axis_tvalid  in  1  master data valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  slave ready.
- data_out  out  DATA_W  head-of-FIFO data; all zeros when data_valid=0.
- data_valid  out  1  head word available to user.
- data_last  out  1  head word is the last beat of its packet; 0 when data_valid=0.
- data_ready  in  1  user pop; a pop occurs when data_valid & data_ready.
- fill_level  out  CNT_W  words currently stored (0..DEPTH).
- pkt_stored  out  CNT_W  complete packets (tlast stored) in FIFO.
- err_oversize  out  1  one-cycle pulse; see Behaviour.

Behaviour:
- Reset: one clock, synchronous, active-high. While s_axis_arst=1 and in the cycle after it deasserts, all outputs are 0, pointers and counters are 0, FSM is IDLE. Reset mid-packet discards all buffered data and any partial packet with no error pulse.
- Accept: a push occurs on tvalid & tready. tready = (fill_level != DEPTH), driven from registered state only (no combinational path from tvalid or data_ready). Full with a simultaneous pop: tready stays 0 that cycle and rises the next cycle.
- Push and pop in the same cycle: fill_level is unchanged. Pointers wrap modulo DEPTH.
- Latency, cut-through: a word accepted at edge N gives data_valid=1 from cycle N+1. data_valid = (fill_level != 0).
- Latency, store-and-forward: data_valid = (fill_level != 0) & (pkt_stored != 0 | fsm == OVERSIZE). The first word of a packet becomes visible the cycle after its tlast beat is accepted.
- pkt_stored: +1 on a push with tlast=1, -1 on a pop with data_last=1. Both in the same cycle leave it unchanged.
- Input FSM (tracks the packet currently being received):
  - IDLE -> IN_PKT on a push with tlast=0. A push with tlast=1 is a single-beat packet and stays in IDLE.
  - IN_PKT -> IDLE on a push with tlast=1.
  - IN_PKT -> OVERSIZE when STORE_FWD=1, fill_level==DEPTH and pkt_stored==0. This is the deadlock case: the packet is longer than the buffer. err_oversize pulses for exactly 1 cycle on this transition.
  - OVERSIZE: output is released in cut-through fashion. Returns to IDLE on a push with tlast=1.
  - With STORE_FWD=0, OVERSIZE is unreachable.
- The tlast bit is stored alongside data: FIFO entry width is DATA_W+1.
- tvalid=0 while in IN_PKT has no effect on the state; gaps within a packet are legal.
- Data accepted with tready=0 is illegal master behaviour and is ignored.

Optional Feature:
- Macro AXIS_SLAVE_PBUF_STATS_EN.
- Defined: adds output ports rx_pkt_count[31:0] (+1 per accepted tlast beat) and rx_beat_count[31:0] (+1 per accepted beat). Both are free-running, wrap at 2^32 and are cleared by reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package axis_pkg holds:
  - typedef enum logic [1:0] axis_rx_state_t: IDLE=2'b00, IN_PKT=2'b01, OVERSIZE=2'b10.
  - Function clog2-based width helpers.
- One sub-module, axis_sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, wdata, rdata, level, full, empty; first-word-fall-through.
  - It is reused by later blocks.
- axis_slave_pbuf contains the FSM, packet counting and the mode gating around it.

Test Plan:
- Cut-through, DEPTH=16: 4-beat packet A0..A3 (tlast on A3), data_ready=1 -> data_valid rises 1 cycle after A0 is accepted; outputs A0..A3 in order, data_last only with A3; fill_level returns to 0.
- Backpressure: data_ready=0, stream 20 beats -> tready falls after the 16th accept with fill_level=16. Raising data_ready for 1 cycle gives one pop; tready=1 the next cycle and exactly one more beat is accepted.
- Store-and-forward: send 3-beat packet with 2-cycle tvalid gaps -> data_valid stays 0 until the cycle after the tlast accept, then pkt_stored=1. After the 3 pops, pkt_stored=0.
- Oversize: STORE_FWD=1, DEPTH=8, 12-beat packet -> err_oversize pulses once when fill_level hits 8; data drains; all 12 beats are output in order; FSM returns to IDLE after tlast.
- Reset mid-packet: assert s_axis_arst after 5 beats of a 10-beat packet -> next cycle data_valid=0, fill_level=0, pkt_stored=0, tready=0. A fresh 2-beat packet afterwards passes intact.
- Stats (macro defined): 3 packets totalling 10 beats -> rx_pkt_count=3, rx_beat_count=10; both read 0 after reset.
